pe_window_sequencer: RTL and testbench
======================================

// Module: pe_window_sequencer
// PURPOSE
//  Drives the shared 4x4 PE matrix through one layer pass.
//  Layer is split into 6-wide windows. Each window is accumulated over all input channels.
//  Per channel, the block issues the weight passes: 3x3 = E_MODE; 5x5 = A,B,C,D (9+6+6+4 taps).
//  Each pass steps pe_state ONE..SIX, one output column per cycle.
//  Sits between the layer controller and the PE matrix.
//  Tells the PEs when to clear their psums and when to push them to the psum FIFOs.
// PARAMETERS
//  WIN_CNT_W  16  width of window count/index
//  CIN_CNT_W  10  width of input-channel count/index
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          synchronous active-low reset
//  start        in   1          1-cycle pulse; latches config; ignored while busy
//  kernel_mode  in   1          0: 3x3, 1: 5x5
//  num_windows  in   WIN_CNT_W  windows in this layer
//  num_cin      in   CIN_CNT_W  input channels accumulated per window
//  act_valid    in   1          activation/weight operands valid this cycle
//  fifo_full    in   1          any PE psum FIFO full
//  busy         out  1          high from cycle after start until done
//  done         out  1          1-cycle pulse, layer finished
//  pe_en        out  1          PE matrix computes this cycle
//  pe_state     out  3          PE_state_t; IDLE when not running
//  wt_mode      out  3          PE_weight_mode_t of current pass
//  first_acc    out  1          PE clears psum before accumulating (cin 0, first pass)
//  last_acc     out  1          PE pushes psum to FIFO (last cin, last pass)
//  win_idx      out  WIN_CNT_W  current window
//  cin_idx      out  CIN_CNT_W  current input channel
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: busy=0, done=0, pe_en=0, pe_state=IDLE, wt_mode=A_MODE,
//    first_acc=0, last_acc=0, win_idx=0, cin_idx=0.
//  - FSM S_IDLE -> S_RUN -> S_DONE -> S_IDLE.
//  - start in S_IDLE latches the config.
//    - If num_windows==0 or num_cin==0: go to S_DONE; no pe_en ever asserts.
//  - S_RUN loop order, innermost first:
//    - col ONE..SIX
//    - pass (E_MODE only for 3x3; A,B,C,D for 5x5)
//    - cin 0..num_cin-1
//    - win 0..num_windows-1
//  - pe_state/wt_mode/indices show the current position. pe_en=1 and the position advances only when
//    act_valid && !(last_acc && fifo_full).
//    - Otherwise pe_en=0 and the position is held.
//    - This covers a stall on any col, including ONE and SIX.
//  - first_acc and last_acc are level outputs for the current position, held through stalls.
//    - For 3x3 with num_cin=1, both are high on all six columns.
//  - Advance from the final position (last win, last cin, last pass, SIX) enters S_DONE.
//    - done=1 for one cycle; busy, pe_state and pe_en drop in that same cycle.
//    - Next cycle: S_IDLE.
//  - Cycle timing: start at cycle T gives S_RUN with pe_state=ONE at T+1.
//    - Minimum run length is num_windows*num_cin*npass*6 cycles (npass=1 or 4).
//  - start is ignored while busy or in S_DONE.
//  - rst_n=0 at any point returns to the reset values on the next edge; partial work is discarded.
// CONFIGURATION
//  - PE_SEQ_PERF_CNT_EN defined:
//    - Adds output stall_cnt [31:0].
//    - Counts S_RUN cycles with pe_en=0; saturates at 2^32-1.
//    - Cleared by reset and by an accepted start.
//  - Not defined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  1. 3x3, win=1, cin=1, act_valid=1, fifo_full=0, start@T
//     -> pe_en high T+1..T+6; pe_state ONE..SIX; wt_mode=E_MODE; first_acc=last_acc=1 all six; done@T+7.
//  2. 5x5, win=2, cin=3, no stalls
//     -> 144 pe_en cycles; wt_mode A,B,C,D x6 each; first_acc only cin0/A; last_acc only cin2/D; done once.
//  3. Test 1 with fifo_full=1 for 4 cycles while pe_state=THREE
//     -> THREE held, pe_en=0 for 4 cycles, then resume; done@T+11.
//  4. 5x5, win=1, cin=2; act_valid=0 for 3 cycles at cin0/B/FIVE
//     -> position held, no pe_en; total run 51 cycles (48 pe_en + 3 stall).
//  5. num_cin=0, start@T -> done@T+1, pe_en never 1. A second start during a busy run is ignored.
//  6. rst_n=0 mid-run at cin1 -> next cycle all outputs at reset values.
//     A new start then runs the full sequence from win 0.

Source files
------------

// File: rtl/pe_window_sequencer_if.sv
// Control bus between the layer controller (master) and the PE window sequencer (slave).
// PE_SEQ_PERF_CNT_EN adds the stall_cnt performance counter to the bus.
interface pe_window_sequencer_if #(
    parameter int unsigned WIN_CNT_W = 16,
    parameter int unsigned CIN_CNT_W = 10
);
    logic                 start;
    logic                 kernel_mode;
    logic [WIN_CNT_W-1:0] num_windows;
    logic [CIN_CNT_W-1:0] num_cin;
    logic                 act_valid;
    logic                 fifo_full;
    logic                 busy;
    logic                 done;
    logic                 pe_en;
    logic [2:0]           pe_state;
    logic [2:0]           wt_mode;
    logic                 first_acc;
    logic                 last_acc;
    logic [WIN_CNT_W-1:0] win_idx;
    logic [CIN_CNT_W-1:0] cin_idx;
`ifdef PE_SEQ_PERF_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    modport master (
        output start, kernel_mode, num_windows, num_cin, act_valid, fifo_full,
        input  busy, done, pe_en, pe_state, wt_mode, first_acc, last_acc, win_idx, cin_idx
`ifdef PE_SEQ_PERF_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  start, kernel_mode, num_windows, num_cin, act_valid, fifo_full,
        output busy, done, pe_en, pe_state, wt_mode, first_acc, last_acc, win_idx, cin_idx
`ifdef PE_SEQ_PERF_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/pe_window_sequencer.sv
// Steps the shared 4x4 PE matrix through window/cin/pass/column for one layer pass.
// Optional PE_SEQ_PERF_CNT_EN adds a saturating stall counter (stall_cnt).
module pe_window_sequencer #(
    parameter int unsigned WIN_CNT_W = 16,
    parameter int unsigned CIN_CNT_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pe_window_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {PE_IDLE = 3'd0, PE_ONE, PE_TWO, PE_THREE,
                              PE_FOUR, PE_FIVE, PE_SIX} pe_state_t;
    typedef enum logic [2:0] {A_MODE = 3'd0, B_MODE, C_MODE, D_MODE, E_MODE} wt_mode_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [WIN_CNT_W-1:0] nwin_q, nwin_d;
    logic [CIN_CNT_W-1:0] ncin_q, ncin_d;
    pe_state_t            col_q, col_d;
    logic [1:0]           pass_q, pass_d;
    logic [CIN_CNT_W-1:0] cin_q, cin_d;
    logic [WIN_CNT_W-1:0] win_q, win_d;
    wt_mode_t             wt_q, wt_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 pe_en_q, pe_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 run_n;
    logic [1:0]           last_pass;
`ifdef PE_SEQ_PERF_CNT_EN
    logic [31:0]          stall_q, stall_d;
`endif

    assign last_pass = mode_q ? 2'd3 : 2'd0;

    // Next position; outputs are computed for the position held in the coming cycle,
    // so pe_en qualifies that cycle using act_valid/fifo_full sampled at this edge.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        nwin_d  = nwin_q;
        ncin_d  = ncin_q;
        col_d   = col_q;
        pass_d  = pass_q;
        cin_d   = cin_q;
        win_d   = win_q;
        done_d  = 1'b0;
        run_n   = 1'b0;
`ifdef PE_SEQ_PERF_CNT_EN
        stall_d = stall_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.kernel_mode;
                    nwin_d = bus.num_windows;
                    ncin_d = bus.num_cin;
                    col_d  = PE_ONE;
                    pass_d = 2'd0;
                    cin_d  = '0;
                    win_d  = '0;
`ifdef PE_SEQ_PERF_CNT_EN
                    stall_d = '0;
`endif
                    if (bus.num_windows == '0 || bus.num_cin == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        run_n   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                run_n = 1'b1;
`ifdef PE_SEQ_PERF_CNT_EN
                if (!pe_en_q && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
`endif
                if (pe_en_q) begin
                    if (col_q != PE_SIX) begin
                        col_d = pe_state_t'(col_q + 3'd1);
                    end else begin
                        col_d = PE_ONE;
                        if (pass_q != last_pass) begin
                            pass_d = pass_q + 2'd1;
                        end else begin
                            pass_d = 2'd0;
                            if (cin_q != ncin_q - CIN_CNT_W'(1)) begin
                                cin_d = cin_q + CIN_CNT_W'(1);
                            end else begin
                                cin_d = '0;
                                if (win_q != nwin_q - WIN_CNT_W'(1)) begin
                                    win_d = win_q + WIN_CNT_W'(1);
                                end else begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                    run_n   = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (!run_n) begin
            col_d  = PE_IDLE;
            pass_d = 2'd0;
            cin_d  = '0;
            win_d  = '0;
        end
        wt_d    = !run_n ? A_MODE : (mode_d ? wt_mode_t'({1'b0, pass_d}) : E_MODE);
        first_d = run_n && (cin_d == '0) && (pass_d == 2'd0);
        last_d  = run_n && (cin_d == ncin_d - CIN_CNT_W'(1))
                        && (pass_d == (mode_d ? 2'd3 : 2'd0));
        pe_en_d = run_n && bus.act_valid && !(last_d && bus.fifo_full);
        busy_d  = run_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            nwin_q  <= '0;
            ncin_q  <= '0;
            col_q   <= PE_IDLE;
            pass_q  <= 2'd0;
            cin_q   <= '0;
            win_q   <= '0;
            wt_q    <= A_MODE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pe_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PE_SEQ_PERF_CNT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            nwin_q  <= nwin_d;
            ncin_q  <= ncin_d;
            col_q   <= col_d;
            pass_q  <= pass_d;
            cin_q   <= cin_d;
            win_q   <= win_d;
            wt_q    <= wt_d;
            first_q <= first_d;
            last_q  <= last_d;
            pe_en_q <= pe_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PE_SEQ_PERF_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pe_en     = pe_en_q;
    assign bus.pe_state  = col_q;
    assign bus.wt_mode   = wt_q;
    assign bus.first_acc = first_q;
    assign bus.last_acc  = last_q;
    assign bus.win_idx   = win_q;
    assign bus.cin_idx   = cin_q;
`ifdef PE_SEQ_PERF_CNT_EN
    assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pe_window_sequencer.sv
// Directed bench for pe_window_sequencer with a scoreboard of expected PE positions.
// Stall counter checks are included when PE_SEQ_PERF_CNT_EN is defined.
module tb_pe_window_sequencer;
    localparam int unsigned WW = 16;
    localparam int unsigned CW = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pe_cnt   = 0;
    int   done_cnt = 0;
    logic [35:0] sb_q[$];

    always #5 clk = ~clk;

    pe_window_sequencer_if #(.WIN_CNT_W(WW), .CIN_CNT_W(CW)) bus ();
    pe_window_sequencer #(.WIN_CNT_W(WW), .CIN_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {pe_state, wt_mode, first, last, win, cin} for every compute cycle.
    task automatic push_seq(input logic mode, input int nwin, input int ncin);
        int npass;
        npass = mode ? 4 : 1;
        for (int w = 0; w < nwin; w++)
            for (int c = 0; c < ncin; c++)
                for (int p = 0; p < npass; p++)
                    for (int col = 1; col <= 6; col++)
                        sb_q.push_back({3'(col), (mode ? 3'(p) : 3'd4),
                                        (c == 0 && p == 0),
                                        (c == ncin - 1 && p == npass - 1),
                                        16'(w), 10'(c)});
    endtask

    always @(negedge clk) begin
        if (bus.pe_en === 1'b1) begin
            pe_cnt++;
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0)
                chk("sb_position", 64'({bus.pe_state, bus.wt_mode, bus.first_acc, bus.last_acc,
                                        bus.win_idx, bus.cin_idx}), 64'(sb_q.pop_front()));
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic start_run(input logic mode, input int nwin, input int ncin);
        bus.kernel_mode = mode;
        bus.num_windows = 16'(nwin);
        bus.num_cin     = 10'(ncin);
        if (nwin > 0 && ncin > 0) push_seq(mode, nwin, ncin);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, inout int at);
        while (bus.done !== 1'b1 && at < limit) begin
            tick();
            at++;
        end
    endtask

    // Called in the done cycle: checks the drop of busy/pe_en, then totals one cycle later.
    task automatic end_checks(input string t, input int p0, input int d0, input int npe);
        chk({t, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({t, "_pe_en_at_done"}, 64'(bus.pe_en), 64'd0);
        chk({t, "_pe_state_at_done"}, 64'(bus.pe_state), 64'd0);
        tick();
        chk({t, "_done_pulse_len"}, 64'(bus.done), 64'd0);
        chk({t, "_pe_en_count"}, 64'(pe_cnt - p0), 64'(npe));
        chk({t, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({t, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic reset_checks(input string t);
        chk({t, "_busy"}, 64'(bus.busy), 64'd0);
        chk({t, "_done"}, 64'(bus.done), 64'd0);
        chk({t, "_pe_en"}, 64'(bus.pe_en), 64'd0);
        chk({t, "_pe_state"}, 64'(bus.pe_state), 64'd0);
        chk({t, "_wt_mode"}, 64'(bus.wt_mode), 64'd0);
        chk({t, "_first"}, 64'(bus.first_acc), 64'd0);
        chk({t, "_last"}, 64'(bus.last_acc), 64'd0);
        chk({t, "_win"}, 64'(bus.win_idx), 64'd0);
        chk({t, "_cin"}, 64'(bus.cin_idx), 64'd0);
    endtask

    initial begin
        int at, p0, d0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.kernel_mode = 1'b0; bus.num_windows = '0; bus.num_cin = '0;
        bus.act_valid = 1'b0; bus.fifo_full = 1'b0;
        repeat (3) tick();
        reset_checks("rst");
        rst_n = 1'b1;
        tick();

        // 1: 3x3, one window, one channel
        bus.act_valid = 1'b1;
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b0, 1, 1); at = 1;
        chk("t1_busy_t1", 64'(bus.busy), 64'd1);
        chk("t1_state_t1", 64'(bus.pe_state), 64'd1);
        chk("t1_pe_en_t1", 64'(bus.pe_en), 64'd1);
        wait_done(50, at);
        chk("t1_done_cycle", 64'(at), 64'd7);
        end_checks("t1", p0, d0, 6);

        // 2: 5x5, 2 windows, 3 channels
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b1, 2, 3); at = 1;
        wait_done(400, at);
        chk("t2_done_cycle", 64'(at), 64'd145);
        end_checks("t2", p0, d0, 144);

        // 3: fifo_full stall on the last-acc column THREE
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b0, 1, 1); at = 1;
        tick(); at++;
        chk("t3_state_two", 64'(bus.pe_state), 64'd2);
        bus.fifo_full = 1'b1;
        tick(); at++;
        chk("t3_hold_three_a", 64'(bus.pe_state), 64'd3);
        chk("t3_stall_a", 64'(bus.pe_en), 64'd0);
        chk("t3_last_held", 64'(bus.last_acc), 64'd1);
        tick(); at++;
        tick(); at++;
        tick(); at++;
        chk("t3_hold_three_b", 64'(bus.pe_state), 64'd3);
        chk("t3_stall_b", 64'(bus.pe_en), 64'd0);
        bus.fifo_full = 1'b0;
        tick(); at++;
        chk("t3_resume_state", 64'(bus.pe_state), 64'd3);
        chk("t3_resume_pe_en", 64'(bus.pe_en), 64'd1);
        wait_done(50, at);
        chk("t3_done_cycle", 64'(at), 64'd11);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("t3_stall_cnt", 64'(bus.stall_cnt), 64'd4);
`endif
        end_checks("t3", p0, d0, 6);

        // 4: act_valid gap at cin0/B/FIVE
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b1, 1, 2); at = 1;
        while (at < 10) begin tick(); at++; end
        bus.act_valid = 1'b0;
        tick(); at++;
        chk("t4_hold_state", 64'(bus.pe_state), 64'd5);
        chk("t4_hold_wt", 64'(bus.wt_mode), 64'd1);
        chk("t4_hold_cin", 64'(bus.cin_idx), 64'd0);
        chk("t4_stall_a", 64'(bus.pe_en), 64'd0);
        tick(); at++;
        tick(); at++;
        chk("t4_stall_b", 64'(bus.pe_en), 64'd0);
        chk("t4_hold_state_b", 64'(bus.pe_state), 64'd5);
        bus.act_valid = 1'b1;
        wait_done(200, at);
        chk("t4_done_cycle", 64'(at), 64'd52);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("t4_stall_cnt", 64'(bus.stall_cnt), 64'd3);
`endif
        end_checks("t4", p0, d0, 48);

        // 5a: zero channels finishes immediately
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b0, 1, 0); at = 1;
        chk("t5_zero_done", 64'(bus.done), 64'd1);
        end_checks("t5z", p0, d0, 0);

        // 5b: start while busy and while in S_DONE is ignored
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b0, 1, 1); at = 1;
        tick(); at++;
        bus.kernel_mode = 1'b1; bus.num_windows = 16'd5; bus.num_cin = 10'd3;
        bus.start = 1'b1;
        tick(); at++;
        bus.start = 1'b0;
        wait_done(50, at);
        chk("t5_busy_start_done_cycle", 64'(at), 64'd7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t5_done_start_busy", 64'(bus.busy), 64'd0);
        chk("t5_done_start_pe_en_cnt", 64'(pe_cnt - p0), 64'd6);
        chk("t5_done_start_done_cnt", 64'(done_cnt - d0), 64'd1);
        tick();
        chk("t5_done_start_idle", 64'(bus.busy), 64'd0);

        // 6: reset mid-run at cin1, then a clean rerun
        start_run(1'b1, 1, 2); at = 1;
        while (at < 30) begin tick(); at++; end
        chk("t6_mid_cin", 64'(bus.cin_idx), 64'd1);
        rst_n = 1'b0;
        tick();
        reset_checks("t6_rst");
        sb_q.delete();
        rst_n = 1'b1;
        tick();
        p0 = pe_cnt; d0 = done_cnt;
        start_run(1'b1, 1, 2); at = 1;
        chk("t6_restart_win", 64'(bus.win_idx), 64'd0);
        chk("t6_restart_first", 64'(bus.first_acc), 64'd1);
        wait_done(200, at);
        chk("t6_done_cycle", 64'(at), 64'd49);
        end_checks("t6", p0, d0, 48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
